// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
//
// Shared definitions for the round-robin 4:1 mux arbiter:
//   - requester count and select width
//   - arbiter state encoding (IDLE / GRANT)
//   - index-to-one-hot grant constants and a lookup helper
//
// No ports (package).
// -----------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // One-hot grant patterns, indexed by requester number (a=0 .. d=3).
  localparam logic [NUM_REQ-1:0] ONEHOT_0 = 4'b0001;
  localparam logic [NUM_REQ-1:0] ONEHOT_1 = 4'b0010;
  localparam logic [NUM_REQ-1:0] ONEHOT_2 = 4'b0100;
  localparam logic [NUM_REQ-1:0] ONEHOT_3 = 4'b1000;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    case (idx)
      2'd0:    oh = ONEHOT_0;
      2'd1:    oh = ONEHOT_1;
      2'd2:    oh = ONEHOT_2;
      default: oh = ONEHOT_3;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Purely combinational round-robin winner search. Starting just after the
// last-served requester, scans last+1, last+2, last+3 and finally last itself
// (all mod 4); the first asserted request wins.
//
// Ports:
//   req   [3:0] in   request vector, bit i = requester i
//   last  [1:0] in   index of the last-served requester
//   idx   [1:0] out  winning requester index (0 when none found)
//   found       out  at least one request was asserted
// -----------------------------------------------------------------------------
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [SEL_W-1:0] cand;

  // NOTE: every variable driven here gets a default before the loop, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // The 2-bit add wraps naturally, so offset NUM_REQ lands back on last,
    // which is therefore the lowest-priority candidate.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_4x1_rr_arbiter
//
// Round-robin arbiter sharing one 4:1 mux datapath between four requesters.
// Each requester owns one mux input (a..d). One grant is active at a time;
// the grantee's index drives the registered selects {s1,s0}, and the selected
// input is registered onto out one cycle later. A grant is held for at most
// HOLD consecutive cycles, and is released early by done[idx] or by the
// grantee dropping its request. On release the next winner is granted in the
// same edge, with no idle bubble.
//
// Optional feature (macro MUX_ARB_LOCK_EN): adds input lock; while lock=1 the
// quantum expiry is ignored and the hold counter saturates at HOLD-1.
//
// Parameters:
//   DW    data width of a..d and out
//   HOLD  grant quantum in cycles (>= 1)
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   req   [3:0] in   per-requester request (a=0, b=1, c=2, d=3)
//   done  [3:0] in   grant release, honoured only for the current grantee
//   lock        in   (MUX_ARB_LOCK_EN only) suppress quantum expiry
//   a,b,c,d     in   mux data inputs, DW bits each
//   gnt   [3:0] out  registered one-hot grant
//   s0, s1      out  registered mux selects (LSB, MSB)
//   out         out  registered mux output
//   busy        out  high while a grant is active
// -----------------------------------------------------------------------------
module mux_4x1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW   = 1,
  parameter int HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
`ifdef MUX_ARB_LOCK_EN
  input  logic               lock,
`endif
  input  logic [DW-1:0]      a,
  input  logic [DW-1:0]      b,
  input  logic [DW-1:0]      c,
  input  logic [DW-1:0]      d,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s0,
  output logic               s1,
  output logic [DW-1:0]      out,
  output logic               busy
);

  localparam int               CNT_W   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [SEL_W-1:0]   last_q,  last_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [DW-1:0]      out_q,   out_d;

  logic               quantum_up;
  logic               release_now;
  logic [SEL_W-1:0]   pick_last;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;
  logic [DW-1:0]      mux_data;

  // ---------------------------------------------------------------------------
  // Release decision. In GRANT the select register always holds the grantee's
  // index, so it doubles as idx.
  // ---------------------------------------------------------------------------
  assign quantum_up = (cnt_q == CNT_MAX)
`ifdef MUX_ARB_LOCK_EN
                      && !lock
`endif
                      ;

  assign release_now = (state_q == GRANT) &&
                       (done[sel_q] || !req[sel_q] || quantum_up);

  // On release the search must already see the grantee as last-served, so
  // it re-arbitrates against the updated pointer within the same edge.
  assign pick_last = release_now ? sel_q : last_q;

  rr_pick u_rr_pick (
    .req   (req),
    .last  (pick_last),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // ---------------------------------------------------------------------------
  // 4:1 datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    case (sel_q)
      2'd0:    mux_data = a;
      2'd1:    mux_data = b;
      2'd2:    mux_data = c;
      default: mux_data = d;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    out_d   = '0;

    case (state_q)
      IDLE: begin
        // out stays 0 through any cycle that follows a non-busy cycle;
        // the selects keep their previous value while nothing is granted.
        gnt_d = '0;
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = idx_to_onehot(pick_idx);
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end

      GRANT: begin
        out_d = mux_data;
        if (release_now) begin
          last_d = sel_q;
          cnt_d  = '0;
          if (pick_found) begin
            gnt_d = idx_to_onehot(pick_idx);
            sel_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (cnt_q != CNT_MAX) begin
          // Saturation only matters while lock suppresses expiry; otherwise
          // reaching CNT_MAX always releases first.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order. All registers
  // here are small control/data flops and all are reset; last_q resets to 3
  // so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign gnt  = gnt_q;
  assign s0   = sel_q[0];
  assign s1   = sel_q[1];
  assign out  = out_q;
  assign busy = (state_q == GRANT);

endmodule
